// File: rtl/reg_main_mc_if.sv
// Host register bus between usb_reg_main (master) and the main register block (slave).
interface reg_main_mc_if #(
  parameter int unsigned pBYTECNT_SIZE = 7
);
  logic [7:0]               reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic [7:0]               read_data;
  logic [7:0]               write_data;
  logic                     reg_read;
  logic                     reg_write;
  logic                     reg_addrvalid;

  modport master (
    output reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
    input  read_data
  );

  modport slave (
    input  reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
    output read_data
  );
endinterface

// File: rtl/reg_main_mc.sv
// Main register page: build time, front-end select, multi-channel FWFT FIFO record reader
// with empty marker, saturating underflow counter and an autonomous flush engine.
module reg_main_mc #(
  parameter int unsigned           pBYTECNT_SIZE    = 7,
  parameter int unsigned           pCHANNELS        = 2,
  parameter int unsigned           pFIFO_WIDTH      = 18,
  parameter int unsigned           pSTAT_WIDTH      = 6,
  parameter int unsigned           pRECORD_BYTES    = 4,
  parameter logic [pFIFO_WIDTH-1:0] pEMPTY_WORD     = 18'h30000,
  parameter logic [1:0]            pPAGE            = 2'b00,
  parameter int unsigned           pFE_SELECT_WIDTH = 2
) (
  input  logic                               cwusb_clk,
  input  logic                               reset_i,
  reg_main_mc_if.slave                       bus,
  input  logic [31:0]                        buildtime_i,
  input  logic [pCHANNELS*pFIFO_WIDTH-1:0]   I_fifo_data,
  input  logic [pCHANNELS*pSTAT_WIDTH-1:0]   I_fifo_status,
  input  logic [pCHANNELS-1:0]               I_fifo_empty,
  output logic [pCHANNELS-1:0]               O_fifo_read,
  output logic [pFE_SELECT_WIDTH-1:0]        fe_select,
  output logic                               selected
);
  localparam int unsigned D  = (pFIFO_WIDTH + 7) / 8;
  localparam int unsigned HW = D * 8;
  localparam int unsigned CW = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1;
  localparam logic [pBYTECNT_SIZE-1:0] RecMod  = pBYTECNT_SIZE'(pRECORD_BYTES);
  localparam logic [pBYTECNT_SIZE-1:0] RecLast = pBYTECNT_SIZE'(pRECORD_BYTES - 1);
  localparam logic [pBYTECNT_SIZE-1:0] StatIdx = pBYTECNT_SIZE'(D);

  typedef enum logic [1:0] {StIdle, StDrain, StDone} flush_st_e;

  flush_st_e                   st_q, st_d;
  logic [CW-1:0]               chan_q, chan_d, flush_chan_q, flush_chan_d;
  logic [pFE_SELECT_WIDTH-1:0] fe_select_q, fe_select_d;
  logic [15:0]                 uf_q, uf_d;
  logic                        flag_q, flag_d;
  logic [HW-1:0]               hold_q, hold_d;
  logic [7:0]                  rdata_q, rdata_d;
  logic [pCHANNELS-1:0]        empty_r_q;

  logic [5:0]                  a;
  logic [pBYTECNT_SIZE-1:0]    r;
  logic                        rd_en, wr_en, fifo_hit, rd0, busy;
  logic                        chan_wr, uf_wr, flush_wr;
  logic [pFIFO_WIDTH-1:0]      head;
  logic [pSTAT_WIDTH-1:0]      stat;
  logic                        empty_r_sel, live_empty, flush_live_empty;
  logic [HW-1:0]               src_ext;
  logic [7:0]                  fifo_byte;

  assign selected = bus.reg_addrvalid && (bus.reg_address[7:6] == pPAGE);
  assign a        = bus.reg_address[5:0];
  assign r        = bus.reg_bytecnt % RecMod;
  assign rd_en    = selected && bus.reg_read;
  assign wr_en    = selected && bus.reg_write;
  assign fifo_hit = rd_en && (a == 6'h04);
  assign rd0      = fifo_hit && (r == '0);
  assign chan_wr  = wr_en && (a == 6'h02);
  assign uf_wr    = wr_en && (a == 6'h05);
  assign flush_wr = wr_en && (a == 6'h06);
  assign busy     = (st_q != StIdle);
  assign fe_select = fe_select_q;

  // Per-channel mux for the selected channel and the latched flush channel.
  always_comb begin
    head             = '0;
    stat             = '0;
    empty_r_sel      = 1'b1;
    live_empty       = 1'b1;
    flush_live_empty = 1'b1;
    for (int i = 0; i < pCHANNELS; i++) begin
      if (chan_q == CW'(i)) begin
        head        = I_fifo_data[i*pFIFO_WIDTH +: pFIFO_WIDTH];
        stat        = I_fifo_status[i*pSTAT_WIDTH +: pSTAT_WIDTH];
        empty_r_sel = empty_r_q[i];
        live_empty  = I_fifo_empty[i];
      end
      if (flush_chan_q == CW'(i)) begin
        flush_live_empty = I_fifo_empty[i];
      end
    end
  end

  // A busy flush masks the FIFO so host reads see the empty marker.
  assign src_ext = HW'((busy || empty_r_sel) ? pEMPTY_WORD : head);

  // Combinational FIFO_RD byte: live byte 0, captured bytes, then status, then zero.
  always_comb begin
    fifo_byte = '0;
    if (r == '0) begin
      fifo_byte = src_ext[7:0];
    end else if (r == StatIdx) begin
      fifo_byte[pSTAT_WIDTH-1:0] = stat;
    end else begin
      for (int i = 1; i < D; i++) begin
        if (r == pBYTECNT_SIZE'(i)) fifo_byte = hold_q[i*8 +: 8];
      end
    end
  end

  assign bus.read_data = reset_i ? 8'h00 : (fifo_hit ? fifo_byte : rdata_q);

  // Registered register-read data, zero when nothing of ours is being read.
  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      unique case (a)
        6'h00:   rdata_d = buildtime_i[bus.reg_bytecnt[1:0]*8 +: 8];
        6'h01:   rdata_d[pFE_SELECT_WIDTH-1:0] = fe_select_q;
        6'h02:   rdata_d[CW-1:0] = chan_q;
        6'h03:   rdata_d[pSTAT_WIDTH-1:0] = stat;
        6'h05:   rdata_d = bus.reg_bytecnt[0] ? uf_q[15:8] : uf_q[7:0];
        6'h06:   rdata_d[0] = busy;
        default: rdata_d = '0;
      endcase
    end
  end

  // Config registers, record capture, empty flag and underflow counter.
  always_comb begin
    fe_select_d = fe_select_q;
    chan_d      = chan_q;
    flag_d      = flag_q;
    hold_d      = hold_q;
    uf_d        = uf_q;
    if (wr_en && (a == 6'h01)) fe_select_d = bus.write_data[pFE_SELECT_WIDTH-1:0];
    if (chan_wr && (bus.write_data < 8'(pCHANNELS))) chan_d = bus.write_data[CW-1:0];
    if (rd0) begin
      flag_d = empty_r_sel;
      hold_d = src_ext;
      if (empty_r_sel && !busy && (uf_q != 16'hFFFF)) uf_d = uf_q + 16'd1;
    end else if (fifo_hit && (r == RecLast)) begin
      flag_d = 1'b0;
    end
    // A channel change always starts a fresh record.
    if (chan_wr) flag_d = 1'b0;
    // Clear beats a same-cycle increment.
    if (uf_wr) uf_d = '0;
  end

  // Flush FSM next state; the channel is latched when the drain starts.
  always_comb begin
    st_d         = st_q;
    flush_chan_d = flush_chan_q;
    unique case (st_q)
      StIdle: begin
        if (flush_wr && bus.write_data[0]) begin
          st_d         = StDrain;
          flush_chan_d = chan_q;
        end
      end
      StDrain: if (flush_live_empty) st_d = StDone;
      StDone:  st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  // One-hot pop strobes: flush drain, else one pop per non-empty record at byte 0.
  always_comb begin
    O_fifo_read = '0;
    for (int i = 0; i < pCHANNELS; i++) begin
      if (!reset_i && !I_fifo_empty[i]) begin
        if (st_q == StDrain) begin
          if (flush_chan_q == CW'(i)) O_fifo_read[i] = 1'b1;
        end else if (!busy && rd0 && !flag_q && !empty_r_sel && (chan_q == CW'(i))) begin
          O_fifo_read[i] = 1'b1;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      st_q         <= StIdle;
      chan_q       <= '0;
      flush_chan_q <= '0;
      fe_select_q  <= '0;
      uf_q         <= '0;
      flag_q       <= 1'b0;
      hold_q       <= '0;
      rdata_q      <= '0;
      empty_r_q    <= '1;
    end else begin
      st_q         <= st_d;
      chan_q       <= chan_d;
      flush_chan_q <= flush_chan_d;
      fe_select_q  <= fe_select_d;
      uf_q         <= uf_d;
      flag_q       <= flag_d;
      hold_q       <= hold_d;
      rdata_q      <= rdata_d;
      empty_r_q    <= I_fifo_empty;
    end
  end
endmodule

// File: tb/tb_reg_main_mc.sv
// Directed bench for reg_main_mc: register table, FIFO records, underflow saturation,
// flush drain and asynchronous reset in the middle of a record and of a flush.
module tb_reg_main_mc;
  logic             clk;
  logic             rst;
  logic [31:0]      buildtime;
  logic [1:0][17:0] head;
  logic [1:0][5:0]  stat;
  logic [1:0]       fifo_empty;
  logic [1:0]       fifo_read;
  logic [1:0]       fe_sel;
  logic             sel;

  int unsigned fill [2];
  int unsigned popped [2];
  int unsigned bad_pop;
  int passed;
  int total;

  reg_main_mc_if #(.pBYTECNT_SIZE(7)) bus_if ();

  reg_main_mc dut (
    .cwusb_clk    (clk),
    .reset_i      (rst),
    .bus          (bus_if),
    .buildtime_i  (buildtime),
    .I_fifo_data  (head),
    .I_fifo_status(stat),
    .I_fifo_empty (fifo_empty),
    .O_fifo_read  (fifo_read),
    .fe_select    (fe_sel),
    .selected     (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FWFT FIFO model: word count is fill minus pops seen.
  assign fifo_empty[0] = (fill[0] == popped[0]);
  assign fifo_empty[1] = (fill[1] == popped[1]);

  always @(posedge clk) begin
    if (fifo_read[0]) popped[0] <= popped[0] + 1;
    if (fifo_read[1]) popped[1] <= popped[1] + 1;
    if ((fifo_read[0] && fifo_empty[0]) || (fifo_read[1] && fifo_empty[1]) ||
        (fifo_read == 2'b11)) bad_pop <= bad_pop + 1;
  end

  typedef struct {
    logic [7:0] addr;
    logic [6:0] bc;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    bus_if.reg_address   = addr;
    bus_if.write_data    = data;
    bus_if.reg_addrvalid = 1'b1;
    bus_if.reg_write     = 1'b1;
    @(posedge clk); #1;
    bus_if.reg_write = 1'b0;
  endtask

  // comb: read_data mid-cycle; regd: read_data the cycle after the strobe.
  task automatic rd(input logic [7:0] addr, input logic [6:0] bc,
                    output logic [7:0] comb, output logic [7:0] regd, output logic [1:0] pop);
    @(posedge clk); #1;
    bus_if.reg_address   = addr;
    bus_if.reg_bytecnt   = bc;
    bus_if.reg_addrvalid = 1'b1;
    bus_if.reg_read      = 1'b1;
    #4;
    comb = bus_if.read_data;
    pop  = fifo_read;
    @(posedge clk); #1;
    bus_if.reg_read = 1'b0;
    regd = bus_if.read_data;
  endtask

  task automatic rec_byte(input string name, input logic [6:0] bc,
                          input logic [7:0] exp, input logic [1:0] exp_pop);
    logic [7:0] c, g;
    logic [1:0] p;
    rd(8'h04, bc, c, g, p);
    check({name, " data"}, {24'h0, c}, {24'h0, exp});
    check({name, " pop"}, {30'h0, p}, {30'h0, exp_pop});
  endtask

  task automatic reg_rd(input string name, input logic [7:0] addr, input logic [6:0] bc,
                        input logic [7:0] exp);
    logic [7:0] c, g;
    logic [1:0] p;
    rd(addr, bc, c, g, p);
    check(name, {24'h0, g}, {24'h0, exp});
  endtask

  initial begin
    logic [7:0] c, g;
    logic [1:0] p;
    int unsigned p0;
    bit done;
    passed  = 0;
    total   = 0;
    bad_pop = 0;
    popped[0] = 0;
    popped[1] = 0;
    fill[0] = 0;
    fill[1] = 1;
    head[0] = 18'h00000;
    head[1] = 18'h2ABCD;
    stat[0] = 6'h2A;
    stat[1] = 6'h15;
    buildtime = 32'h12345678;
    bus_if.reg_address   = '0;
    bus_if.reg_bytecnt   = '0;
    bus_if.write_data    = '0;
    bus_if.reg_read      = 1'b0;
    bus_if.reg_write     = 1'b0;
    bus_if.reg_addrvalid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // 1: reset state and register read table.
    check("reset fe_select", {30'h0, fe_sel}, 32'h0);
    check("reset fifo_read", {30'h0, fifo_read}, 32'h0);
    tbl[0] = '{8'h00, 7'd0, 8'h78};
    tbl[1] = '{8'h00, 7'd1, 8'h56};
    tbl[2] = '{8'h00, 7'd2, 8'h34};
    tbl[3] = '{8'h00, 7'd3, 8'h12};
    tbl[4] = '{8'h01, 7'd0, 8'h00};
    tbl[5] = '{8'h02, 7'd0, 8'h00};
    tbl[6] = '{8'h05, 7'd0, 8'h00};
    tbl[7] = '{8'h06, 7'd0, 8'h00};
    tbl[8] = '{8'h40, 7'd0, 8'h00};
    for (int i = 0; i < 9; i++) begin
      rd(tbl[i].addr, tbl[i].bc, c, g, p);
      check($sformatf("table[%0d] addr %0h", i, tbl[i].addr), {24'h0, g}, {24'h0, tbl[i].exp});
    end
    bus_if.reg_address = 8'h40;
    #1 check("selected off-page", {31'h0, sel}, 32'h0);
    bus_if.reg_address = 8'h01;
    #1 check("selected on-page", {31'h0, sel}, 32'h1);

    // 2: channel 1 record with repeated byte index.
    wr(8'h01, 8'h03);
    check("fe_select written", {30'h0, fe_sel}, 32'h3);
    wr(8'h02, 8'h01);
    wr(8'h02, 8'h05);
    reg_rd("chan ignores >=pCHANNELS", 8'h02, 7'd0, 8'h01);
    reg_rd("stat ch1", 8'h03, 7'd0, 8'h15);
    rec_byte("ch1 b0", 7'd0, 8'hCD, 2'b10);
    rec_byte("ch1 b1", 7'd1, 8'hAB, 2'b00);
    rec_byte("ch1 b1 repeat", 7'd5, 8'hAB, 2'b00);
    rec_byte("ch1 b2", 7'd2, 8'h02, 2'b00);
    rec_byte("ch1 b3", 7'd3, 8'h15, 2'b00);
    check("ch1 pop count", popped[1], 32'd1);

    // 3: empty record on channel 0, then real data.
    wr(8'h02, 8'h00);
    rec_byte("empty b0", 7'd0, 8'h00, 2'b00);
    rec_byte("empty b1", 7'd1, 8'h00, 2'b00);
    rec_byte("empty b2", 7'd2, 8'h03, 2'b00);
    rec_byte("empty b3", 7'd3, 8'h2A, 2'b00);
    reg_rd("underflow=1", 8'h05, 7'd0, 8'h01);
    head[0] = 18'h1F00D;
    fill[0] = 1;
    repeat (3) @(posedge clk);
    rec_byte("ch0 b0", 7'd0, 8'h0D, 2'b01);
    rec_byte("ch0 b1", 7'd1, 8'hF0, 2'b00);
    rec_byte("ch0 b2", 7'd2, 8'h01, 2'b00);
    rec_byte("ch0 b3", 7'd3, 8'h2A, 2'b00);
    check("ch0 pop count", popped[0], 32'd1);

    // 4: underflow saturation with back-to-back empty byte-0 reads.
    wr(8'h05, 8'h00);
    @(posedge clk); #1;
    bus_if.reg_address = 8'h04;
    bus_if.reg_bytecnt = 7'd0;
    bus_if.reg_read    = 1'b1;
    repeat (65535) @(posedge clk);
    #1 bus_if.reg_read = 1'b0;
    reg_rd("underflow lo at 65535", 8'h05, 7'd0, 8'hFF);
    reg_rd("underflow hi at 65535", 8'h05, 7'd1, 8'hFF);
    rec_byte("extra empty b0", 7'd0, 8'h00, 2'b00);
    reg_rd("underflow lo saturated", 8'h05, 7'd0, 8'hFF);
    reg_rd("underflow hi saturated", 8'h05, 7'd1, 8'hFF);
    wr(8'h05, 8'h00);
    reg_rd("underflow lo cleared", 8'h05, 7'd0, 8'h00);
    reg_rd("underflow hi cleared", 8'h05, 7'd1, 8'h00);

    // 5: flush channel 1 holding five words.
    wr(8'h02, 8'h01);
    fill[1] = popped[1] + 5;
    repeat (3) @(posedge clk);
    p0 = popped[1];
    wr(8'h06, 8'h01);
    reg_rd("busy during drain", 8'h06, 7'd0, 8'h01);
    rd(8'h04, 7'd0, c, g, p);
    check("drain b0 marker", {24'h0, c}, 32'h0);
    rd(8'h04, 7'd2, c, g, p);
    check("drain b2 marker", {24'h0, c}, 32'h03);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      rd(8'h06, 7'd0, c, g, p);
      if (g == 8'h00) done = 1'b1;
    end
    check("flush completes", {31'h0, done}, 32'h1);
    check("flush pop count", popped[1] - p0, 32'd5);
    check("ch1 empty after flush", {31'h0, fifo_empty[1]}, 32'h1);
    reg_rd("no underflow from drain", 8'h05, 7'd0, 8'h00);

    // 6a: reset in the middle of a record.
    fill[1] = popped[1] + 2;
    repeat (3) @(posedge clk);
    rec_byte("pre-reset b0", 7'd0, 8'hCD, 2'b10);
    rec_byte("pre-reset b1", 7'd1, 8'hAB, 2'b00);
    p0 = popped[1];
    @(posedge clk); #1;
    bus_if.reg_address = 8'h04;
    bus_if.reg_bytecnt = 7'd0;
    bus_if.reg_read    = 1'b1;
    rst = 1'b1;
    #1;
    check("reset pop", {30'h0, fifo_read}, 32'h0);
    check("reset read_data", {24'h0, bus_if.read_data}, 32'h0);
    check("reset fe_select mid-record", {30'h0, fe_sel}, 32'h0);
    #2 bus_if.reg_read = 1'b0;
    @(negedge clk) rst = 1'b0;
    check("no pop across reset", popped[1], p0);
    reg_rd("chan after reset", 8'h02, 7'd0, 8'h00);

    // 6b: reset in the middle of a flush.
    wr(8'h02, 8'h01);
    fill[1] = fill[1] + 3;
    repeat (3) @(posedge clk);
    wr(8'h06, 8'h01);
    p0 = popped[1];
    rst = 1'b1;
    #1 check("reset pop mid-flush", {30'h0, fifo_read}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    check("flush stopped by reset", popped[1], p0);
    reg_rd("busy after reset", 8'h06, 7'd0, 8'h00);
    wr(8'h02, 8'h01);
    rec_byte("post-reset b0", 7'd0, 8'hCD, 2'b10);
    rec_byte("post-reset b1", 7'd1, 8'hAB, 2'b00);
    rec_byte("post-reset b2", 7'd2, 8'h02, 2'b00);
    rec_byte("post-reset b3", 7'd3, 8'h15, 2'b00);
    check("pops never illegal", bad_pop, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
